// File: rtl/axi_lite_scratch_regs.sv
// AXI4-Lite scratch register bank, terminal slave of an AXI-Lite cut chain.
// AW and W are accepted independently; B and R are registered with one
// outstanding transaction per channel. Register contents and per-register
// write pulses are exposed to local logic.
// Optional feature macro: AXI_LITE_SCRATCH_STRB_EN (byte-strobe writes).
// Without it, only full-word strobes are accepted; anything else is SLVERR.

package axi_lite_scratch_pkg;
  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } ax_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct packed { logic [1:0] resp; logic user; } b_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic user; } r_t;
  typedef struct packed {
    ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    ax_t ar; logic ar_valid; logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready; logic w_ready; b_t b; logic b_valid;
    logic ar_ready; r_t r; logic r_valid;
  } resp_t;
endpackage

module axi_lite_scratch_regs #(
  parameter int unsigned          NumRegs   = 8,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter type axi_req_t  = axi_lite_scratch_pkg::req_t,
  parameter type axi_resp_t = axi_lite_scratch_pkg::resp_t
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  axi_req_t                       slv_req_i,
  output axi_resp_t                      slv_resp_o,
  output logic [NumRegs*DataWidth-1:0]   reg_q_o,
  output logic [NumRegs-1:0]             wr_pulse_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffBits   = $clog2(StrbWidth);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_HAVE_AW = 2'd1;
  localparam logic [1:0] W_HAVE_W  = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;
  localparam logic       R_IDLE    = 1'b0;
  localparam logic       R_RESP    = 1'b1;

  logic [1:0]                        wstate_q, wstate_d;
  logic                              rstate_q, rstate_d;
  logic [NumRegs-1:0][DataWidth-1:0] regs_q, regs_d;
  logic [AddrWidth-1:0]              awaddr_q, awaddr_d;
  logic [DataWidth-1:0]              wdata_q, wdata_d;
  logic [StrbWidth-1:0]              wstrb_q, wstrb_d;
  logic [1:0]                        b_resp_q, b_resp_d;
  logic [NumRegs-1:0]                wr_pulse_q, wr_pulse_d;
  logic [DataWidth-1:0]              r_data_q, r_data_d;
  logic [1:0]                        r_resp_q, r_resp_d;

  logic                 aw_ready, w_ready, ar_ready;
  logic                 aw_hs, w_hs, ar_hs, commit;
  logic [AddrWidth-1:0] cm_addr, cm_idx, ar_idx;
  logic [DataWidth-1:0] cm_data, ar_data;
  logic [StrbWidth-1:0] cm_strb;
  logic                 cm_hit, cm_we, cm_pulse, ar_hit;
  logic                 unused_ok;

  assign unused_ok = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

  function automatic logic [AddrWidth-1:0] decode_idx(input logic [AddrWidth-1:0] a);
    return (a - BaseAddr) >> OffBits;
  endfunction

  function automatic logic decode_hit(input logic [AddrWidth-1:0] a);
    return (a >= BaseAddr) && (decode_idx(a) < AddrWidth'(NumRegs));
  endfunction

  // Write channel: independent AW/W capture, commit once both are present, then B.
  always_comb begin
    wstate_d   = wstate_q;
    regs_d     = regs_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    b_resp_d   = b_resp_q;
    wr_pulse_d = '0;
    commit     = 1'b0;

    aw_ready = !((wstate_q == W_HAVE_AW) || (wstate_q == W_RESP));
    w_ready  = !((wstate_q == W_HAVE_W)  || (wstate_q == W_RESP));
    aw_hs    = slv_req_i.aw_valid && aw_ready;
    w_hs     = slv_req_i.w_valid && w_ready;

    if (aw_hs) awaddr_d = slv_req_i.aw.addr;
    if (w_hs) begin
      wdata_d = slv_req_i.w.data;
      wstrb_d = slv_req_i.w.strb;
    end

    // Commit payload comes from the held copy for whichever half arrived earlier.
    cm_addr = (wstate_q == W_HAVE_AW) ? awaddr_q : slv_req_i.aw.addr;
    cm_data = (wstate_q == W_HAVE_W)  ? wdata_q  : slv_req_i.w.data;
    cm_strb = (wstate_q == W_HAVE_W)  ? wstrb_q  : slv_req_i.w.strb;
    cm_idx  = decode_idx(cm_addr);
    cm_hit  = decode_hit(cm_addr);
`ifdef AXI_LITE_SCRATCH_STRB_EN
    cm_we    = cm_hit;
    cm_pulse = cm_hit && (|cm_strb);
`else
    cm_we    = cm_hit && (&cm_strb);
    cm_pulse = cm_we;
`endif

    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) commit = 1'b1;
        else if (aw_hs)    wstate_d = W_HAVE_AW;
        else if (w_hs)     wstate_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  commit = 1'b1;
      W_HAVE_W:  if (aw_hs) commit = 1'b1;
      default:   if (slv_req_i.b_ready) wstate_d = W_IDLE;
    endcase

    if (commit) begin
      wstate_d = W_RESP;
      b_resp_d = cm_we ? RESP_OKAY : RESP_SLVERR;
      for (int unsigned k = 0; k < NumRegs; k++) begin
        if (cm_idx == AddrWidth'(k)) begin
          wr_pulse_d[k] = cm_pulse;
          for (int unsigned b = 0; b < StrbWidth; b++) begin
            if (cm_we && cm_strb[b]) regs_d[k][b*8 +: 8] = cm_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read channel: sample the current register value on AR, hold R until r_ready.
  always_comb begin
    rstate_d = rstate_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    ar_data  = '0;
    ar_ready = (rstate_q == R_IDLE);
    ar_hs    = slv_req_i.ar_valid && ar_ready;
    ar_idx   = decode_idx(slv_req_i.ar.addr);
    ar_hit   = decode_hit(slv_req_i.ar.addr);
    for (int unsigned k = 0; k < NumRegs; k++) begin
      if (ar_hit && (ar_idx == AddrWidth'(k))) ar_data = regs_q[k];
    end
    if (rstate_q == R_IDLE) begin
      if (ar_hs) begin
        rstate_d = R_RESP;
        r_data_d = ar_data;
        r_resp_d = ar_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (slv_req_i.r_ready) begin
      rstate_d = R_IDLE;
    end
  end

  // State and payload registers; reset discards any in-flight transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      regs_q     <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      b_resp_q   <= RESP_OKAY;
      wr_pulse_q <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      regs_q     <= regs_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      b_resp_q   <= b_resp_d;
      wr_pulse_q <= wr_pulse_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  // Response struct assembly; user fields tied off.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = (wstate_q == W_RESP);
    slv_resp_o.b.resp   = b_resp_q;
    slv_resp_o.b.user   = '0;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.r_valid  = (rstate_q == R_RESP);
    slv_resp_o.r.data   = r_data_q;
    slv_resp_o.r.resp   = r_resp_q;
    slv_resp_o.r.user   = '0;
  end

  assign reg_q_o    = regs_q;
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_scratch_regs.sv
// Directed bench for axi_lite_scratch_regs (NumRegs=8, 32-bit, BaseAddr=0x1000).
module tb_axi_lite_scratch_regs;
  import axi_lite_scratch_pkg::*;

  localparam logic [31:0] BASE = 32'h1000;

  logic         clk = 1'b0;
  logic         rst;
  req_t         req;
  resp_t        resp;
  logic [255:0] reg_q;
  logic [7:0]   wr_pulse;

  logic [31:0] exp_regs [8];
  int n_vec = 0;
  int n_err = 0;

  axi_lite_scratch_regs #(
    .NumRegs(8), .AddrWidth(32), .DataWidth(32), .BaseAddr(BASE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .slv_req_i(req), .slv_resp_o(resp),
    .reg_q_o(reg_q), .wr_pulse_o(wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] exp_flat();
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[k*32 +: 32] = exp_regs[k];
    return f;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] bresp, output bit to);
    bit aw_d, w_d, aw_h, w_h;
    int n;
    to = 1'b0; bresp = 2'bxx;
    req.aw.addr = addr; req.w.data = data; req.w.strb = strb;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
    aw_d = 1'b0; w_d = 1'b0; n = 0;
    while (!(aw_d && w_d) && n < 20) begin
      aw_h = req.aw_valid && resp.aw_ready;
      w_h  = req.w_valid && resp.w_ready;
      step();
      if (aw_h) begin req.aw_valid = 1'b0; aw_d = 1'b1; end
      if (w_h)  begin req.w_valid  = 1'b0; w_d  = 1'b1; end
      n++;
    end
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    n = 0;
    while (!resp.b_valid && n < 20) begin step(); n++; end
    if (!resp.b_valid) to = 1'b1;
    else begin bresp = resp.b.resp; step(); end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] rresp, output bit to);
    bit ar_h;
    int n;
    to = 1'b0; data = 'x; rresp = 2'bxx;
    req.ar.addr = addr; req.ar_valid = 1'b1; req.r_ready = 1'b1;
    n = 0;
    while (req.ar_valid && n < 20) begin
      ar_h = resp.ar_ready;
      step();
      if (ar_h) req.ar_valid = 1'b0;
      n++;
    end
    req.ar_valid = 1'b0;
    n = 0;
    while (!resp.r_valid && n < 20) begin step(); n++; end
    if (!resp.r_valid) to = 1'b1;
    else begin data = resp.r.data; rresp = resp.r.resp; step(); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; req.b_ready = 1'b1; req.r_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_regs[k] = '0;
    step(); step();
    rst = 1'b0;
    #1;
    n_vec++; if (resp.b_valid !== 1'b0) begin n_err++; $display("FAIL reset_bvalid: got %0b want 0", resp.b_valid); end
    n_vec++; if (resp.r_valid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %0b want 0", resp.r_valid); end
    n_vec++; if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b111) begin n_err++; $display("FAIL reset_readies: got %b want 111", {resp.aw_ready, resp.w_ready, resp.ar_ready}); end
    n_vec++; if (reg_q !== '0) begin n_err++; $display("FAIL reset_regs: got %h want 0", reg_q); end
    n_vec++; if (wr_pulse !== 8'h00) begin n_err++; $display("FAIL reset_pulse: got %h want 00", wr_pulse); end
    step();
  endtask

  task automatic test_basic_write();
    logic [31:0] d; logic [1:0] r; bit to;
    req.aw.addr = BASE + 32'd4; req.w.data = 32'hDEADBEEF; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
    step();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    exp_regs[1] = 32'hDEADBEEF;
    n_vec++; if (resp.b_valid !== 1'b1) begin n_err++; $display("FAIL basic_bvalid: got %0b want 1", resp.b_valid); end
    n_vec++; if (resp.b.resp !== 2'b00) begin n_err++; $display("FAIL basic_bresp: got %b want 00", resp.b.resp); end
    n_vec++; if (wr_pulse !== 8'h02) begin n_err++; $display("FAIL basic_pulse: got %h want 02", wr_pulse); end
    n_vec++; if (resp.aw_ready !== 1'b0 || resp.w_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy_readies: got %b%b want 00", resp.aw_ready, resp.w_ready); end
    step();
    n_vec++; if (wr_pulse !== 8'h00) begin n_err++; $display("FAIL basic_pulse_end: got %h want 00", wr_pulse); end
    n_vec++; if (resp.b_valid !== 1'b0) begin n_err++; $display("FAIL basic_bvalid_end: got %0b want 0", resp.b_valid); end
    n_vec++; if (resp.aw_ready !== 1'b1 || resp.w_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_readies: got %b%b want 11", resp.aw_ready, resp.w_ready); end
    n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL basic_regs: got %h want %h", reg_q, exp_flat()); end
    axi_read(BASE + 32'd4, d, r, to);
    n_vec++; if (to || d !== 32'hDEADBEEF || r !== 2'b00) begin n_err++; $display("FAIL basic_read: got %h/%b to=%0b want deadbeef/00", d, r, to); end
    axi_read(BASE + 32'd7, d, r, to);
    n_vec++; if (to || d !== 32'hDEADBEEF || r !== 2'b00) begin n_err++; $display("FAIL lowbits_read: got %h/%b to=%0b want deadbeef/00", d, r, to); end
  endtask

  task automatic test_w_before_aw();
    req.w.data = 32'h22222222; req.w.strb = 4'hF; req.w_valid = 1'b1;
    step();
    req.w_valid = 1'b0;
    n_vec++; if (resp.w_ready !== 1'b0 || resp.aw_ready !== 1'b1) begin n_err++; $display("FAIL wfirst_readies: got w=%0b aw=%0b want w=0 aw=1", resp.w_ready, resp.aw_ready); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++; if (resp.w_ready !== 1'b0 || resp.b_valid !== 1'b0) begin n_err++; $display("FAIL wfirst_wait%0d: got w_ready=%0b b_valid=%0b want 0 0", i, resp.w_ready, resp.b_valid); end
    end
    req.aw.addr = BASE + 32'd8; req.aw_valid = 1'b1;
    step();
    req.aw_valid = 1'b0;
    exp_regs[2] = 32'h22222222;
    n_vec++; if (resp.b_valid !== 1'b1 || resp.b.resp !== 2'b00) begin n_err++; $display("FAIL wfirst_b: got valid=%0b resp=%b want 1 00", resp.b_valid, resp.b.resp); end
    n_vec++; if (wr_pulse !== 8'h04) begin n_err++; $display("FAIL wfirst_pulse: got %h want 04", wr_pulse); end
    step();
    n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL wfirst_regs: got %h want %h", reg_q, exp_flat()); end
  endtask

  task automatic test_miss();
    logic [31:0] d; logic [1:0] r; bit to;
    axi_read(BASE + 32'd32, d, r, to);
    n_vec++; if (to || d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL miss_read_hi: got %h/%b to=%0b want 0/10", d, r, to); end
    axi_read(BASE - 32'd4, d, r, to);
    n_vec++; if (to || d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL miss_read_lo: got %h/%b to=%0b want 0/10", d, r, to); end
    axi_write(BASE + 32'd32, 32'hFFFFFFFF, 4'hF, r, to);
    n_vec++; if (to || r !== 2'b10) begin n_err++; $display("FAIL miss_write_resp: got %b to=%0b want 10", r, to); end
    n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL miss_write_regs: got %h want %h", reg_q, exp_flat()); end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; bit to;
    axi_write(BASE, 32'h1, 4'hF, r, to);
    exp_regs[0] = 32'h1;
    n_vec++; if (to || r !== 2'b00) begin n_err++; $display("FAIL coll_pre_write: got %b to=%0b want 00", r, to); end
    req.aw.addr = BASE; req.w.data = 32'h5; req.w.strb = 4'hF; req.ar.addr = BASE;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    step();
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    exp_regs[0] = 32'h5;
    n_vec++; if (resp.r_valid !== 1'b1 || resp.r.data !== 32'h1) begin n_err++; $display("FAIL coll_old_value: got valid=%0b data=%h want 1 00000001", resp.r_valid, resp.r.data); end
    n_vec++; if (resp.b_valid !== 1'b1 || resp.b.resp !== 2'b00) begin n_err++; $display("FAIL coll_b: got valid=%0b resp=%b want 1 00", resp.b_valid, resp.b.resp); end
    step();
    axi_read(BASE, d, r, to);
    n_vec++; if (to || d !== 32'h5 || r !== 2'b00) begin n_err++; $display("FAIL coll_new_value: got %h/%b to=%0b want 5/00", d, r, to); end
  endtask

  task automatic test_strobe();
    logic [1:0] r; bit to;
    axi_write(BASE + 32'd12, 32'h11223344, 4'hF, r, to);
    exp_regs[3] = 32'h11223344;
    n_vec++; if (to || r !== 2'b00) begin n_err++; $display("FAIL strb_full: got %b to=%0b want 00", r, to); end
    axi_write(BASE + 32'd12, 32'hAABBCCDD, 4'b0011, r, to);
`ifdef AXI_LITE_SCRATCH_STRB_EN
    exp_regs[3] = 32'h1122CCDD;
    n_vec++; if (to || r !== 2'b00) begin n_err++; $display("FAIL strb_partial_resp: got %b to=%0b want 00", r, to); end
`else
    n_vec++; if (to || r !== 2'b10) begin n_err++; $display("FAIL strb_partial_resp: got %b to=%0b want 10", r, to); end
`endif
    n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL strb_partial_regs: got %h want %h", reg_q, exp_flat()); end
    axi_write(BASE + 32'd12, 32'h99999999, 4'b0000, r, to);
`ifdef AXI_LITE_SCRATCH_STRB_EN
    n_vec++; if (to || r !== 2'b00) begin n_err++; $display("FAIL strb_zero_resp: got %b to=%0b want 00", r, to); end
`else
    n_vec++; if (to || r !== 2'b10) begin n_err++; $display("FAIL strb_zero_resp: got %b to=%0b want 10", r, to); end
`endif
    n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL strb_zero_regs: got %h want %h", reg_q, exp_flat()); end
  endtask

  task automatic test_back_to_back();
    req.aw.addr = BASE + 32'd16; req.w.data = 32'h44444444; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
    step();
    exp_regs[4] = 32'h44444444;
    n_vec++; if (resp.b_valid !== 1'b1 || wr_pulse !== 8'h10) begin n_err++; $display("FAIL b2b_first: got valid=%0b pulse=%h want 1 10", resp.b_valid, wr_pulse); end
    req.aw.addr = BASE + 32'd20; req.w.data = 32'h55555555;
    step();
    n_vec++; if (resp.b_valid !== 1'b0 || resp.aw_ready !== 1'b1 || resp.w_ready !== 1'b1 || wr_pulse !== 8'h00) begin n_err++; $display("FAIL b2b_gap: got valid=%0b aw=%0b w=%0b pulse=%h want 0 1 1 00", resp.b_valid, resp.aw_ready, resp.w_ready, wr_pulse); end
    step();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    exp_regs[5] = 32'h55555555;
    n_vec++; if (resp.b_valid !== 1'b1 || wr_pulse !== 8'h20) begin n_err++; $display("FAIL b2b_second: got valid=%0b pulse=%h want 1 20", resp.b_valid, wr_pulse); end
    step();
    n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL b2b_regs: got %h want %h", reg_q, exp_flat()); end
  endtask

  task automatic test_hold_reset();
    logic [1:0] r; bit to;
    req.aw.addr = BASE + 32'd24; req.w.data = 32'h66666666; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b0;
    step();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (resp.b_valid !== 1'b1 || resp.b.resp !== 2'b00 || resp.aw_ready !== 1'b0 || resp.w_ready !== 1'b0) begin n_err++; $display("FAIL hold_cycle%0d: got valid=%0b resp=%b aw=%0b w=%0b want 1 00 0 0", i, resp.b_valid, resp.b.resp, resp.aw_ready, resp.w_ready); end
      step();
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) exp_regs[k] = '0;
    n_vec++; if (resp.b_valid !== 1'b0) begin n_err++; $display("FAIL rst_bvalid: got %0b want 0", resp.b_valid); end
    n_vec++; if (reg_q !== '0 || wr_pulse !== 8'h00) begin n_err++; $display("FAIL rst_regs: got %h pulse=%h want 0 00", reg_q, wr_pulse); end
    step();
    rst = 1'b0;
    req.b_ready = 1'b1;
    #1;
    n_vec++; if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b111) begin n_err++; $display("FAIL rst_readies: got %b want 111", {resp.aw_ready, resp.w_ready, resp.ar_ready}); end
    step();
    n_vec++; if (resp.b_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_stale_b: got %0b want 0", resp.b_valid); end
    axi_write(BASE + 32'd28, 32'h77777777, 4'hF, r, to);
    exp_regs[7] = 32'h77777777;
    n_vec++; if (to || r !== 2'b00 || reg_q !== exp_flat()) begin n_err++; $display("FAIL post_rst_write: got %b to=%0b regs=%h want 00 %h", r, to, reg_q, exp_flat()); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_miss();
    test_collision();
    test_strobe();
    test_back_to_back();
    test_hold_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
